// File: rtl/io_bitbang_seq.sv
// io_bitbang_seq
// Clocked bitbang sequencer. A host pushes per-pin direction/value/hold
// commands into a FIFO. The FSM plays each command onto a bank of tristate
// pins for (hold+1)*(div+1) clocks, then captures a synchronised sample of
// the pins. Back-to-back commands are played with no gap cycle.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_enable         permits starting new steps (never truncates a step)
//   in_div            clocks per tick minus 1, latched at each step load
//   in_cmd_valid      command push request
//   out_cmd_ready     FIFO can accept a command (level < DEPTH)
//   in_cmd_direction  per-pin drive enable for the step (1 = drive)
//   in_cmd_outval     per-pin drive value for the step
//   in_cmd_hold       step length in ticks minus 1
//   out_samp_valid    one-cycle pulse: new sample available
//   out_samp_data     pins sampled at the end of the last step
//   out_busy          FSM is playing a step
//   out_fifo_level    number of queued commands
//   io_pins           pad bank; bit i driven with out_q[i] when dir_q[i]=1
module io_bitbang_seq #(
   parameter int IO_NUM_OF  = 10,
   parameter int DEPTH      = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int HOLD_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_enable,
   input  logic [DIV_WIDTH-1:0]         in_div,
   input  logic                         in_cmd_valid,
   output logic                         out_cmd_ready,
   input  logic [IO_NUM_OF-1:0]         in_cmd_direction,
   input  logic [IO_NUM_OF-1:0]         in_cmd_outval,
   input  logic [HOLD_WIDTH-1:0]        in_cmd_hold,
   output logic                         out_samp_valid,
   output logic [IO_NUM_OF-1:0]         out_samp_data,
   output logic                         out_busy,
   output logic [$clog2(DEPTH+1)-1:0]   out_fifo_level,
   inout  wire  [IO_NUM_OF-1:0]         io_pins
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef enum logic {
      IDLE,
      STEP
   } state_t;

   state_t state_q, state_d;

   // Command FIFO storage (DEPTH is a power of two, so pointers wrap naturally)
   logic [IO_NUM_OF-1:0]  fifo_dir  [DEPTH];
   logic [IO_NUM_OF-1:0]  fifo_out  [DEPTH];
   logic [HOLD_WIDTH-1:0] fifo_hold [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [LW-1:0]         level_q;

   logic                  push;
   logic                  pop;
   logic                  step_end;
   logic                  fifo_nonempty;

   logic [IO_NUM_OF-1:0]  dir_q;
   logic [IO_NUM_OF-1:0]  out_q;
   logic [IO_NUM_OF-1:0]  sync1_q;
   logic [IO_NUM_OF-1:0]  sync_q;
   logic [DIV_WIDTH-1:0]  div_cnt_q;
   logic [DIV_WIDTH-1:0]  div_lat_q;
   logic [HOLD_WIDTH-1:0] hold_cnt_q;

   // No full-bypass: a push is refused when full even if a pop happens now.
   assign out_cmd_ready  = (level_q < LW'(DEPTH));
   assign push           = in_cmd_valid && out_cmd_ready;
   assign fifo_nonempty  = (level_q != '0);
   assign out_fifo_level = level_q;
   assign out_busy       = (state_q == STEP);

   // Pin drive comes only from registers.
   for (genvar i = 0; i < IO_NUM_OF; i++) begin : g_pad
      assign io_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dir[wr_ptr]  <= in_cmd_direction;
         fifo_out[wr_ptr]  <= in_cmd_outval;
         fifo_hold[wr_ptr] <= in_cmd_hold;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Two-flop synchroniser on the pad inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync_q  <= '0;
      end else begin
         sync1_q <= io_pins;
         sync_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      step_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_enable && fifo_nonempty) begin
               pop     = 1'b1;
               state_d = STEP;
            end
         end
         STEP: begin
            if (div_cnt_q == '0 && hold_cnt_q == '0) begin
               step_end = 1'b1;
               // Chain the next command on the same edge: no gap cycle.
               if (in_enable && fifo_nonempty) pop = 1'b1;
               else                            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q          <= '0;
         out_q          <= '0;
         div_cnt_q      <= '0;
         div_lat_q      <= '0;
         hold_cnt_q     <= '0;
         out_samp_valid <= 1'b0;
         out_samp_data  <= '0;
      end else begin
         out_samp_valid <= step_end;
         if (step_end) out_samp_data <= sync_q;

         if (pop) begin
            dir_q      <= fifo_dir[rd_ptr];
            out_q      <= fifo_out[rd_ptr];
            div_cnt_q  <= in_div;
            div_lat_q  <= in_div;
            hold_cnt_q <= fifo_hold[rd_ptr];
         end else if (state_q == STEP) begin
            if (div_cnt_q != '0) begin
               div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
            end else if (hold_cnt_q != '0) begin
               div_cnt_q  <= div_lat_q;
               hold_cnt_q <= hold_cnt_q - HOLD_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_io_bitbang_seq.sv
// Bench for io_bitbang_seq: scoreboard of expected samples filled at push
// time and drained by a monitor on each out_samp_valid pulse.
module tb_io_bitbang_seq;

   localparam int N     = 10;
   localparam int DEPTH = 8;
   localparam int DW    = 16;
   localparam int HW    = 8;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_enable = 1'b0;
   logic [DW-1:0] in_div = '0;
   logic          in_cmd_valid = 1'b0;
   logic          out_cmd_ready;
   logic [N-1:0]  in_cmd_direction = '0;
   logic [N-1:0]  in_cmd_outval = '0;
   logic [HW-1:0] in_cmd_hold = '0;
   logic          out_samp_valid;
   logic [N-1:0]  out_samp_data;
   logic          out_busy;
   logic [LW-1:0] out_fifo_level;
   wire  [N-1:0]  io_pins;

   // External pad drivers
   logic [N-1:0]  pad_en  = '0;
   logic [N-1:0]  pad_val = '0;

   for (genvar i = 0; i < N; i++) begin : g_tbpad
      assign io_pins[i] = pad_en[i] ? pad_val[i] : 1'bz;
   end

   io_bitbang_seq #(
      .IO_NUM_OF (N),
      .DEPTH     (DEPTH),
      .DIV_WIDTH (DW),
      .HOLD_WIDTH(HW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_enable       (in_enable),
      .in_div          (in_div),
      .in_cmd_valid    (in_cmd_valid),
      .out_cmd_ready   (out_cmd_ready),
      .in_cmd_direction(in_cmd_direction),
      .in_cmd_outval   (in_cmd_outval),
      .in_cmd_hold     (in_cmd_hold),
      .out_samp_valid  (out_samp_valid),
      .out_samp_data   (out_samp_data),
      .out_busy        (out_busy),
      .out_fifo_level  (out_fifo_level),
      .io_pins         (io_pins)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_pulses = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] exp_head;

   // Scoreboard drain: every sample pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (out_samp_valid === 1'b1) begin
         n_pulses++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL samp_unexpected: got pulse with data=%h, required no pulse", out_samp_data);
         end else begin
            exp_head = exp_q.pop_front();
            if (out_samp_data !== exp_head) begin
               n_fail++;
               $display("FAIL samp_data: got %h, required %h", out_samp_data, exp_head);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required test completion");
      $fatal(1);
   end

   // Drive one command for one edge; optionally record its expected sample.
   task automatic push(input logic [N-1:0] d, input logic [N-1:0] o,
                       input logic [HW-1:0] h, input bit expect_it,
                       input logic [N-1:0] smp);
      in_cmd_valid     = 1'b1;
      in_cmd_direction = d;
      in_cmd_outval    = o;
      in_cmd_hold      = h;
      if (expect_it) exp_q.push_back(smp);
      @(negedge clk);
      in_cmd_valid = 1'b0;
   endtask

   // Count consecutive negedges with out_busy high, bounded by maxc.
   task automatic measure_busy(input int maxc, output int cnt);
      cnt = 0;
      while (out_busy === 1'b1 && cnt < maxc) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      pad_val = 10'h155;
      pad_en  = 10'h3FF;
      @(negedge clk);
      n_checks++; if (io_pins !== 10'h155) begin n_fail++; $display("FAIL rst_pins_released: got %h, required %h", io_pins, 10'h155); end
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", out_busy); end
      n_checks++; if (out_fifo_level !== LW'(0)) begin n_fail++; $display("FAIL rst_level: got %0d, required 0", out_fifo_level); end
      n_checks++; if (out_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", out_cmd_ready); end
      n_checks++; if (out_samp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_samp_valid: got %b, required 0", out_samp_valid); end
      n_checks++; if (out_samp_data !== 10'h000) begin n_fail++; $display("FAIL rst_samp_data: got %h, required 000", out_samp_data); end
      rst    = 1'b0;
      pad_en = '0;
      @(negedge clk);
   endtask

   // hold=0, div=0: one-clock step. The pads pre-drive the same value so the
   // synchronised sample of such a short step is well defined.
   task automatic test_single;
      int p0;
      p0        = n_pulses;
      in_div    = '0;
      in_enable = 1'b1;
      pad_val   = 10'h2AA;
      pad_en    = 10'h3FF;
      push(10'h3FF, 10'h2AA, 8'd0, 1'b1, 10'h2AA);
      n_checks++; if (out_fifo_level !== LW'(1)) begin n_fail++; $display("FAIL single_level_push: got %0d, required 1", out_fifo_level); end
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_before_pop: got %b, required 0", out_busy); end
      @(negedge clk);
      n_checks++; if (out_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_after_pop: got %b, required 1", out_busy); end
      n_checks++; if (out_fifo_level !== LW'(0)) begin n_fail++; $display("FAIL single_level_pop: got %0d, required 0", out_fifo_level); end
      @(negedge clk);
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL single_step_len: busy got %b, required 0", out_busy); end
      pad_en = '0;
      @(negedge clk);
      n_checks++; if (io_pins !== 10'h2AA) begin n_fail++; $display("FAIL single_pins_held: got %h, required 2AA", io_pins); end
      n_checks++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d, required 1", n_pulses - p0); end
   endtask

   task automatic test_hold_div;
      int cnt, bad, p0;
      p0     = n_pulses;
      in_div = 16'd3;
      push(10'h3FF, 10'h155, 8'd2, 1'b1, 10'h155);
      @(negedge clk);
      cnt = 0;
      bad = 0;
      while (out_busy === 1'b1 && cnt < 40) begin
         if (io_pins !== 10'h155) bad++;
         cnt++;
         @(negedge clk);
      end
      n_checks++; if (cnt !== 12) begin n_fail++; $display("FAIL hold_busy_len: got %0d, required 12", cnt); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_pins: got %0d wrong cycles, required 0", bad); end
      @(negedge clk);
      n_checks++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d, required 1", n_pulses - p0); end
   endtask

   // dir=255 drives half the bank; pads drive 3A5 on the released bits.
   task automatic test_merge;
      int cnt;
      in_div  = 16'd1;
      pad_val = 10'h3A5;
      push(10'h255, 10'h3FF, 8'd3, 1'b1, 10'h3F5);
      @(negedge clk);
      pad_en = 10'h1AA;
      @(negedge clk);
      n_checks++; if (io_pins !== 10'h3F5) begin n_fail++; $display("FAIL merge_pins: got %h, required 3F5", io_pins); end
      measure_busy(40, cnt);
      n_checks++; if (cnt !== 7) begin n_fail++; $display("FAIL merge_busy_rest: got %0d, required 7", cnt); end
      @(negedge clk);
      pad_en = '0;
   endtask

   task automatic test_fifo_full;
      int cnt, p0;
      logic [N-1:0] pat;
      p0        = n_pulses;
      in_enable = 1'b0;
      in_div    = '0;
      for (int i = 0; i < 9; i++) begin
         pat = 10'h3C0 ^ (N'(1) << i);
         n_checks++; if (out_cmd_ready !== (i < DEPTH)) begin n_fail++; $display("FAIL full_ready_%0d: got %b, required %b", i, out_cmd_ready, (i < DEPTH)); end
         push(10'h3FF, pat, 8'd2, (i < DEPTH), pat);
      end
      n_checks++; if (out_fifo_level !== LW'(8)) begin n_fail++; $display("FAIL full_level: got %0d, required 8", out_fifo_level); end
      n_checks++; if (out_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", out_cmd_ready); end
      in_enable = 1'b1;
      @(negedge clk);
      measure_busy(100, cnt);
      n_checks++; if (cnt !== 24) begin n_fail++; $display("FAIL full_b2b_busy: got %0d, required 24", cnt); end
      @(negedge clk);
      n_checks++; if (out_fifo_level !== LW'(0)) begin n_fail++; $display("FAIL full_drained_level: got %0d, required 0", out_fifo_level); end
      n_checks++; if (n_pulses - p0 !== 8) begin n_fail++; $display("FAIL full_pulses: got %0d, required 8", n_pulses - p0); end
   endtask

   task automatic test_enable_drop;
      int cnt, p0;
      p0        = n_pulses;
      in_enable = 1'b1;
      in_div    = 16'd1;
      push(10'h3FF, 10'h0F0, 8'd4, 1'b1, 10'h0F0);
      push(10'h3FF, 10'h30C, 8'd1, 1'b1, 10'h30C);
      push(10'h3FF, 10'h0C3, 8'd1, 1'b1, 10'h0C3);
      in_enable = 1'b0;
      measure_busy(40, cnt);
      n_checks++; if (cnt !== 9) begin n_fail++; $display("FAIL drop_busy_rest: got %0d, required 9", cnt); end
      @(negedge clk);
      n_checks++; if (io_pins !== 10'h0F0) begin n_fail++; $display("FAIL drop_pins_held: got %h, required 0F0", io_pins); end
      n_checks++; if (out_fifo_level !== LW'(2)) begin n_fail++; $display("FAIL drop_level: got %0d, required 2", out_fifo_level); end
      n_checks++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL drop_pulses: got %0d, required 1", n_pulses - p0); end
      repeat (3) @(negedge clk);
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy got %b, required 0", out_busy); end
      in_enable = 1'b1;
      @(negedge clk);
      measure_busy(40, cnt);
      n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL drop_resume_busy: got %0d, required 8", cnt); end
      @(negedge clk);
      n_checks++; if (n_pulses - p0 !== 3) begin n_fail++; $display("FAIL drop_resume_pulses: got %0d, required 3", n_pulses - p0); end
   endtask

   task automatic test_reset_mid_step;
      int p0;
      in_enable = 1'b1;
      in_div    = 16'd1;
      push(10'h3FF, 10'h3C3, 8'd5, 1'b0, '0);
      push(10'h3FF, 10'h111, 8'd0, 1'b0, '0);
      @(negedge clk);
      p0 = n_pulses;
      #2 rst = 1'b1;
      #1 pad_val = 10'h155;
      pad_en = 10'h3FF;
      #1;
      n_checks++; if (io_pins !== 10'h155) begin n_fail++; $display("FAIL mid_rst_pins_released: got %h, required 155", io_pins); end
      n_checks++; if (out_fifo_level !== LW'(0)) begin n_fail++; $display("FAIL mid_rst_level: got %0d, required 0", out_fifo_level); end
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", out_busy); end
      n_checks++; if (out_samp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_samp_valid: got %b, required 0", out_samp_valid); end
      @(negedge clk);
      rst    = 1'b0;
      pad_en = '0;
      repeat (6) @(negedge clk);
      n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_discard: busy got %b, required 0", out_busy); end
      n_checks++; if (n_pulses - p0 !== 0) begin n_fail++; $display("FAIL mid_rst_pulses: got %0d, required 0", n_pulses - p0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold_div();
      test_merge();
      test_fifo_full();
      test_enable_drop();
      test_reset_mid_step();
      test_single();
      repeat (2) @(negedge clk);
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
